// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants for the RV32I core.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // One fetched instruction together with its byte address.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bundle: BRAM read port, decode handshake, redirect/halt controls.
// Latency: wires only.
// Backpressure: instr_ready from decode stalls the instruction stream.
interface fetch_if #(
    parameter int unsigned ADDR_WIDTH = 7
);
    import fetch_pkg::*;

    logic                  mem_read_enable;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [INSTR_W-1:0]    mem_data;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  halt;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [INSTR_W-1:0]    instr;
    logic [31:0]           instr_pc;
    logic                  halted;

    modport master (
        output mem_read_enable, mem_addr, instr_valid, instr, instr_pc, halted,
        input  mem_data, redirect_valid, redirect_pc, halt, instr_ready
    );

    modport slave (
        input  mem_read_enable, mem_addr, instr_valid, instr, instr_pc, halted,
        output mem_data, redirect_valid, redirect_pc, halt, instr_ready
    );

endinterface

// File: rtl/fetch_skid_buffer.sv
// Output register plus one-entry skid holding fetched {instr, pc} packets in order.
// Latency: 1 edge from in_vld to out_vld when the output register is free.
// Backpressure: out_rdy low holds the output; one more word lands in the skid, then in_rdy drops.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    input  logic       in_vld,
    output logic       in_rdy,
    input  fetch_pkt_t in_dat,
    output logic       out_vld,
    input  logic       out_rdy,
    output fetch_pkt_t out_dat
);

    fetch_pkt_t skid_dat;
    logic       skid_vld;
    logic       out_free;

    assign in_rdy   = !skid_vld;
    // The output register can take a new word when empty or being consumed this edge.
    assign out_free = !out_vld || out_rdy;

    // Move words output-ward, skid first, so delivery order matches fetch order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (flush) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (out_free) begin
            if (skid_vld) begin
                out_vld  <= 1'b1;
                out_dat  <= skid_dat;
                skid_vld <= in_vld;
                if (in_vld) begin
                    skid_dat <= in_dat;
                end
            end else begin
                out_vld <= in_vld;
                if (in_vld) begin
                    out_dat <= in_dat;
                end
            end
        end else if (in_vld) begin
            skid_vld <= 1'b1;
            skid_dat <= in_dat;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, reads the sync BRAM, hands {instr, pc} to decode.
// Latency: request edge then capture edge; first instr_valid 2 edges after reset release, 1 instr/cycle.
// Backpressure: issue only while fewer than 2 words would remain buffered, so stalls never drop data.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned PROG_WORDS = 128,
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input logic    clock,
    input logic    reset,
    fetch_if.master bus
);

    localparam logic [31:0] START_PC  = {RESET_PC[31:2], 2'b00};
    localparam logic [29:0] LAST_WORD = 30'(PROG_WORDS - 1);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc;
    logic [31:0]  inflight_pc;
    logic         inflight_q;
    logic         flush;
    logic         issue;
    logic         fire;
    logic         out_vld;
    logic         skid_rdy;
    logic [1:0]   occ;
    logic [1:0]   occ_after;
    logic [31:0]  pc_next;
    logic         redirect_lsb_unused;
    fetch_pkt_t   cap_dat;
    fetch_pkt_t   out_dat;

    // Target bits [1:0] are dropped; keep them referenced so the bundle stays fully used.
    assign redirect_lsb_unused = ^bus.redirect_pc[1:0];

    assign fire      = out_vld && bus.instr_ready;
    assign occ       = {1'b0, out_vld} + {1'b0, !skid_rdy} + {1'b0, inflight_q};
    assign occ_after = occ - {1'b0, fire};
    assign pc_next   = (fetch_pc[31:2] == LAST_WORD) ? START_PC : fetch_pc + 32'd4;

    // FSM next state and flush: halt outranks redirect, and only reset leaves HALTED.
    always_comb begin
        state_d = state_q;
        flush   = 1'b0;
        if (state_q == RUN) begin
            if (bus.halt) begin
                state_d = HALTED;
                flush   = 1'b1;
            end else if (bus.redirect_valid) begin
                flush = 1'b1;
            end
        end
    end

    // Reset gates the strobe directly so the BRAM sees no request while held in reset.
    assign issue = reset && (state_q == RUN) && !flush && (occ_after < 2'd2);

    // PC, FSM and inflight tracking; a flush kills any word still coming back from the BRAM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            fetch_pc    <= START_PC;
            inflight_q  <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
            if (flush && !bus.halt) begin
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            end else if (issue) begin
                fetch_pc <= pc_next;
            end
        end
    end

    assign cap_dat.instr = bus.mem_data;
    assign cap_dat.pc    = inflight_pc;

    fetch_skid_buffer u_skid (
        .clock   (clock),
        .reset   (reset),
        .flush   (flush),
        .in_vld  (inflight_q),
        .in_rdy  (skid_rdy),
        .in_dat  (cap_dat),
        .out_vld (out_vld),
        .out_rdy (bus.instr_ready),
        .out_dat (out_dat)
    );

    assign bus.mem_read_enable = issue;
    assign bus.mem_addr        = fetch_pc[ADDR_WIDTH+1:2];
    assign bus.instr_valid     = out_vld;
    assign bus.instr           = out_dat.instr;
    assign bus.instr_pc        = out_dat.pc;
    assign bus.halted          = (state_q == HALTED);

endmodule
